// File: rtl/ss_signed_stream_decoder.sv
// rtl/ss_signed_stream_decoder.sv - windowed signed decoder for sign-magnitude stochastic bitstreams
//
// Accumulates +1 (IN=1,SIGN_IN=0) / -1 (IN=1,SIGN_IN=1) over windows of
// 2^WINDOW_LOG2 cycles and presents each window total on a valid/ready output.
// A stability monitor raises CONVERGED once CONV_WINDOWS consecutive window
// results each differ from their predecessor by at most TOL.
//
// Ports:
//   CLK        clock, all state on rising edge
//   INIT_N     asynchronous active-low reset, release synchronised (2 flops)
//   EN         run enable; low aborts the current window
//   IN         stochastic magnitude bit
//   SIGN_IN    sign of IN (1 = negative)
//   VALUE_OUT  two's-complement window result, -2^W..+2^W
//   OUT_VALID  VALUE_OUT holds an unconsumed result
//   OUT_READY  consumer accepts VALUE_OUT
//   OVERRUN    sticky: a window result was dropped
//   CONVERGED  stability criterion met

module ss_signed_stream_decoder #(
    parameter int WINDOW_LOG2  = 8,
    parameter int TOL          = 2,
    parameter int CONV_WINDOWS = 4
) (
    input  logic                   CLK,
    input  logic                   INIT_N,
    input  logic                   EN,
    input  logic                   IN,
    input  logic                   SIGN_IN,
    output logic [WINDOW_LOG2+1:0] VALUE_OUT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OVERRUN,
    output logic                   CONVERGED
);

    localparam int VW = WINDOW_LOG2 + 2;
    localparam int SW = $clog2(CONV_WINDOWS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(CONV_WINDOWS);
    localparam logic [VW:0]   TOL_V      = (VW+1)'(TOL);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

    // Reset asserts immediately; release is delayed two edges so no state
    // flop sees INIT_N rising close to a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e                    state_q, state_d;
    logic signed [VW-1:0]      acc_q, acc_d;
    logic [WINDOW_LOG2-1:0]    cnt_q, cnt_d;
    logic signed [VW-1:0]      value_q, value_d;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;
    logic                      conv_q, conv_d;
    logic [SW-1:0]             stable_q, stable_d;
    logic signed [VW-1:0]      prev_q, prev_d;
    logic                      prev_valid_q, prev_valid_d;

    logic signed [VW-1:0]      sample;
    logic signed [VW-1:0]      win_sum;
    logic signed [VW:0]        diff;
    logic [VW:0]               abs_diff;
    logic                      terminal;

    always_comb begin
        sample = '0;
        if (IN) begin
            sample = SIGN_IN ? '1 : {{(VW-1){1'b0}}, 1'b1};
        end
    end

    // Result of a window that ends on this edge includes this edge's sample.
    assign win_sum  = acc_q + sample;
    assign terminal = (cnt_q == '1);
    assign diff     = $signed({win_sum[VW-1], win_sum}) - $signed({prev_q[VW-1], prev_q});
    assign abs_diff = diff[VW] ? $unsigned(-diff) : $unsigned(diff);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        value_d      = value_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        conv_d       = conv_q;
        stable_d     = stable_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;

        // Handshake runs in both states; a load below overrides the drop.
        if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end

        if (!EN) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            if (state_q == S_ACCUM) begin
                stable_d     = '0;
                prev_valid_d = 1'b0;
                conv_d       = 1'b0;
                overrun_d    = 1'b0;
            end
        end else begin
            state_d = S_ACCUM;
            cnt_d   = cnt_q + 1'b1;
            if (terminal) begin
                acc_d = '0;
                if (!valid_q || OUT_READY) begin
                    value_d = win_sum;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                // A dropped result still participates in the stability check.
                if (prev_valid_q && (abs_diff <= TOL_V)) begin
                    stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
                end else begin
                    stable_d = '0;
                end
                conv_d       = (stable_d == STABLE_MAX);
                prev_d       = win_sum;
                prev_valid_d = 1'b1;
            end else begin
                acc_d = win_sum;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            value_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            conv_q       <= 1'b0;
            stable_q     <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            conv_q       <= conv_d;
            stable_q     <= stable_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign VALUE_OUT = value_q;
    assign OUT_VALID = valid_q;
    assign OVERRUN   = overrun_q;
    assign CONVERGED = conv_q;

endmodule

// File: tb/tb_ss_signed_stream_decoder.sv
// tb/tb_ss_signed_stream_decoder.sv - self-checking bench for ss_signed_stream_decoder

module tb_ss_signed_stream_decoder;

    localparam int W    = 3;
    localparam int WIN  = 1 << W;
    localparam int TOLV = 1;
    localparam int CONV = 3;

    logic         CLK;
    logic         INIT_N;
    logic         EN;
    logic         IN;
    logic         SIGN_IN;
    logic [W+1:0] VALUE_OUT;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic         OVERRUN;
    logic         CONVERGED;

    int errors = 0;
    int checks = 0;

    ss_signed_stream_decoder #(
        .WINDOW_LOG2 (W),
        .TOL         (TOLV),
        .CONV_WINDOWS(CONV)
    ) dut (
        .CLK      (CLK),
        .INIT_N   (INIT_N),
        .EN       (EN),
        .IN       (IN),
        .SIGN_IN  (SIGN_IN),
        .VALUE_OUT(VALUE_OUT),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OVERRUN  (OVERRUN),
        .CONVERGED(CONVERGED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a window is a list of signed samples; once it holds
    // 2^W entries their sum is the result.
    int m_samples[$];
    int m_val        = 0;
    bit m_valid      = 0;
    bit m_ovr        = 0;
    bit m_conv       = 0;
    bit m_prev_valid = 0;
    int m_prev       = 0;
    int m_stable     = 0;
    bit m_run        = 0;
    int m_rel        = 0;

    always @(posedge CLK or negedge INIT_N) begin
        int res;
        int d;
        bit hs;
        if (!INIT_N) begin
            m_samples.delete();
            m_val = 0; m_valid = 0; m_ovr = 0; m_conv = 0;
            m_prev_valid = 0; m_prev = 0; m_stable = 0; m_run = 0; m_rel = 0;
        end else if (m_rel < 2) begin
            m_rel++;
        end else begin
            hs = m_valid && OUT_READY;
            if (!EN) begin
                if (m_run) begin
                    m_samples.delete();
                    m_prev_valid = 0; m_stable = 0; m_conv = 0; m_ovr = 0;
                end
                m_run = 0;
                if (hs) m_valid = 0;
            end else begin
                m_run = 1;
                m_samples.push_back(IN ? (SIGN_IN ? -1 : 1) : 0);
                if (m_samples.size() == WIN) begin
                    res = 0;
                    foreach (m_samples[i]) res += m_samples[i];
                    m_samples.delete();
                    if (m_valid && !OUT_READY) m_ovr = 1;
                    else begin m_val = res; m_valid = 1; end
                    d = res - m_prev;
                    if (d < 0) d = -d;
                    if (m_prev_valid && d <= TOLV) m_stable = (m_stable + 1 > CONV) ? CONV : m_stable + 1;
                    else m_stable = 0;
                    m_conv = (m_stable == CONV);
                    m_prev = res;
                    m_prev_valid = 1;
                end else if (hs) begin
                    m_valid = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        check("valid", int'(OUT_VALID), int'(m_valid));
        if (m_valid) check("value", int'($signed(VALUE_OUT)), m_val);
        check("overrun", int'(OVERRUN), int'(m_ovr));
        check("converged", int'(CONVERGED), int'(m_conv));
    end

    task automatic step(input bit en, input bit in, input bit sg, input bit rdy);
        EN = en; IN = in; SIGN_IN = sg; OUT_READY = rdy;
        @(negedge CLK);
    endtask

    task automatic win(input int ones, input bit sg, input bit rdy, input bit rdy_last);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, i < ones, sg, (i == WIN - 1) ? rdy_last : rdy);
        end
    endtask

    initial begin
        logic [W+1:0] neg8;
        int mode;
        int k;
        neg8 = 5'b11000;
        INIT_N = 1'b0; EN = 0; IN = 0; SIGN_IN = 0; OUT_READY = 0;
        repeat (3) @(negedge CLK);
        check("reset_valid", int'(OUT_VALID), 0);
        check("reset_value", int'(VALUE_OUT), 0);
        check("reset_overrun", int'(OVERRUN), 0);
        check("reset_conv", int'(CONVERGED), 0);
        INIT_N = 1'b1;
        repeat (3) step(0, 0, 0, 1);

        win(8, 0, 1, 1);
        check("plus8_value", int'(VALUE_OUT), 8);
        check("plus8_valid", int'(OUT_VALID), 1);
        step(1, 1, 0, 1);
        check("valid_one_cycle", int'(OUT_VALID), 0);
        for (int i = 1; i < WIN; i++) step(1, 1, i % 2, 1);
        check("alt_zero", int'($signed(VALUE_OUT)), 0);
        win(8, 1, 1, 1);
        check("minus8_bits", int'(VALUE_OUT), int'(neg8));
        win(0, 1, 1, 1);
        check("in0_sign1_zero", int'($signed(VALUE_OUT)), 0);
        check("in0_valid", int'(OUT_VALID), 1);

        win(8, 0, 1, 0);
        check("ovr_first", int'($signed(VALUE_OUT)), 8);
        check("ovr_not_yet", int'(OVERRUN), 0);
        win(4, 0, 0, 0);
        check("ovr_held", int'($signed(VALUE_OUT)), 8);
        check("ovr_set", int'(OVERRUN), 1);
        win(2, 0, 0, 1);
        check("accept_and_load", int'($signed(VALUE_OUT)), 2);
        check("accept_and_load_valid", int'(OUT_VALID), 1);

        win(5, 0, 1, 1);
        win(5, 0, 1, 1);
        win(6, 0, 1, 1);
        check("conv_not_yet", int'(CONVERGED), 0);
        win(5, 0, 1, 1);
        check("conv_rise", int'(CONVERGED), 1);
        win(8, 0, 1, 1);
        check("conv_fall", int'(CONVERGED), 0);
        check("ovr_sticky", int'(OVERRUN), 1);

        repeat (5) step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        check("abort_ovr_clear", int'(OVERRUN), 0);
        repeat (2) step(0, 0, 0, 1);
        win(8, 0, 1, 1);
        check("after_abort", int'($signed(VALUE_OUT)), 8);
        check("after_abort_valid", int'(OUT_VALID), 1);

        repeat (3) step(1, 1, 0, 0);
        #2 INIT_N = 1'b0;
        #1;
        check("async_valid", int'(OUT_VALID), 0);
        check("async_value", int'(VALUE_OUT), 0);
        check("async_ovr", int'(OVERRUN), 0);
        @(negedge CLK);
        @(negedge CLK);
        INIT_N = 1'b1;
        repeat (WIN + 1) step(1, 1, 0, 1);
        check("post_reset_no_result", int'(OUT_VALID), 0);
        step(1, 1, 0, 1);
        check("post_reset_valid", int'(OUT_VALID), 1);
        check("post_reset_value", int'($signed(VALUE_OUT)), 8);

        mode = 0; k = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                mode = $urandom_range(0, 2);
                k = $urandom_range(0, WIN);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 INIT_N = 1'b0;
                @(negedge CLK);
                INIT_N = 1'b1;
            end
            case (mode)
                0: step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
                1: step($urandom_range(0, 255) != 0, (c % WIN) < k,
                        $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
                default: step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
                              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ss_signed_stream_decoder.md
Name: ss_signed_stream_decoder

Overview:
Receive-side decoder for the sign-magnitude stochastic bitstreams produced by the ISTRA/ADDSUB datapath (an IN/SIGN_IN pair such as x_out/SIGN_x_out). Over fixed windows of 2^WINDOW_LOG2 cycles it accumulates +1 for each IN=1,SIGN_IN=0 and −1 for each IN=1,SIGN_IN=1. Each window's signed count is presented on a valid/ready output. A stability monitor flags convergence of successive window results.

Parameters:
WINDOW_LOG2, 8, log2 of window length in CLK cycles (≥1)
TOL, 2, max |difference| between consecutive window results counted as stable
CONV_WINDOWS, 4, number of consecutive stable comparisons required for CONVERGED (≥1)

Ports:
CLK  input  1  clock, all state on rising edge
INIT_N  input  1  asynchronous active-low reset
EN  input  1  run enable; low aborts the current window
IN  input  1  stochastic magnitude bit
SIGN_IN  input  1  sign of IN (1 = negative)
VALUE_OUT  output  WINDOW_LOG2+2  two's-complement window result, range −2^W..+2^W
OUT_VALID  output  1  VALUE_OUT holds an unconsumed result
OUT_READY  input  1  consumer accepts VALUE_OUT
OVERRUN  output  1  sticky: a window result was dropped
CONVERGED  output  1  stability criterion met

Behaviour:
- Reset (INIT_N low, asynchronous): accumulator, cycle counter, VALUE_OUT, OUT_VALID, OVERRUN, CONVERGED, stable counter, prev-valid flag all 0. Deassertion is synchronised internally to a 2-flop release.
- States: IDLE (EN=0) and ACCUM (EN=1). IDLE→ACCUM on the first edge EN is sampled high; that cycle's IN is window sample 0.
- ACCUM: each edge, acc += (IN ? (SIGN_IN ? −1 : +1) : 0); IN=0 contributes 0 regardless of SIGN_IN. Cycle counter increments modulo 2^W.
- Terminal cycle (counter = 2^W−1): the result includes that cycle's sample and is loaded into the output register on the same edge. OUT_VALID is high the following cycle (latency 1 after the last sample). The accumulator restarts from 0 with the next sample, with no gap cycles.
- Accumulator width is W+2 signed; it cannot overflow. +2^W and −2^W are both representable.
- Handshake: transfer occurs on an edge with OUT_VALID=1 and OUT_READY=1. OUT_VALID falls the next cycle unless a new result loads on that same edge, in which case OUT_VALID stays high with the new value and there is no overrun.
- Overrun: a new result arrives while OUT_VALID=1 and OUT_READY=0. The held value is kept, the new value is discarded, and OVERRUN sets. The discarded value still feeds the convergence compare. OVERRUN clears only on reset or on an EN 1→0 transition.
- Convergence: on every window completion, if prev-valid is set and |new − prev| ≤ TOL, stable = min(stable+1, CONV_WINDOWS); otherwise stable = 0. Then prev ← new and prev-valid ← 1. CONVERGED = (stable == CONV_WINDOWS), registered and updated on the same edge as the result load.
- EN 1→0 mid-window: partial window discarded; accumulator, cycle counter, stable counter, prev-valid and CONVERGED clear; OVERRUN clears. The output register and OUT_VALID are retained until accepted; the handshake remains functional in IDLE.
- EN low on the terminal cycle: the window is aborted, not completed.
- Reset mid-window or mid-handshake: immediate return to the reset state; no partial result is emitted.

Test Plan:
- WINDOW_LOG2=3, EN=1, IN=1,SIGN_IN=0 for 8 cycles, OUT_READY=1 -> VALUE_OUT=+8 (5'b01000), OUT_VALID high exactly 1 cycle, 1 cycle after the 8th sample.
- IN=1 for 8 cycles with SIGN_IN alternating 0/1 -> VALUE_OUT=0; all SIGN_IN=1 -> VALUE_OUT=−8 (5'b11000); IN=0 with SIGN_IN=1 -> 0.
- OUT_READY=0 across two windows (+8 then +4) -> VALUE_OUT stays +8 and OVERRUN=1. Raise OUT_READY on the edge the third window loads (+2) -> OUT_VALID stays high with VALUE_OUT=+2.
- TOL=1, CONV_WINDOWS=3, window results +5,+5,+6,+5 -> CONVERGED rises with the 4th result. A following +8 -> CONVERGED falls on that load.
- EN dropped at cycle 5 of a window, raised 3 cycles later, then 8 cycles of +1 -> a single result +8 with no contribution from the aborted samples; stable counter restarted.
- INIT_N pulsed low asynchronously mid-window while OUT_VALID=1 -> all outputs 0 immediately. After release, the first result appears 2^W cycles after EN is sampled high, plus 1 cycle.
